// File: rtl/ship_ctl_if.sv
// ============================================================================
// Module      : ship_ctl_if
// Description : Control inputs and draw/game outputs of the player-ship controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface ship_ctl_if;
   logic        vblnk_in;
   logic        left_btn;
   logic        right_btn;
   logic        fire_btn;
   logic        hit;
   logic        restart;
   logic [10:0] xpos;
   logic        dead_ship;
   logic [1:0]  lives;
   logic        game_over;
   logic        fire_pulse;

   modport master (
      output vblnk_in, left_btn, right_btn, fire_btn, hit, restart,
      input  xpos, dead_ship, lives, game_over, fire_pulse
   );

   modport slave (
      input  vblnk_in, left_btn, right_btn, fire_btn, hit, restart,
      output xpos, dead_ship, lives, game_over, fire_pulse
   );
endinterface

`default_nettype wire

// File: rtl/ship_ctl.sv
// ============================================================================
// Module      : ship_ctl
// Description : Per-frame ship movement, hits/lives/respawn and fire cooldown.
//               Define SHIP_BLINK_EN to blink the ship while invulnerable.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ship_ctl #(
   parameter int X_MIN          = 0,
   parameter int X_MAX          = 940,
   parameter int X_START        = 470,
   parameter int STEP           = 4,
   parameter int LIVES          = 3,
   parameter int RESPAWN_FRAMES = 120,
   parameter int INVULN_FRAMES  = 90,
   parameter int FIRE_COOLDOWN  = 15
) (
   input  logic        pclk,
   input  logic        rst_n,
   ship_ctl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_ALIVE     = 2'd0,
      ST_DEAD      = 2'd1,
      ST_INVULN    = 2'd2,
      ST_GAME_OVER = 2'd3
   } state_t;

   localparam logic [11:0] c_X_MIN        = 12'(X_MIN);
   localparam logic [11:0] c_X_MAX        = 12'(X_MAX);
   localparam logic [11:0] c_STEP         = 12'(STEP);
   localparam logic [10:0] c_X_START      = 11'(X_START);
   localparam logic [1:0]  c_LIVES        = 2'(LIVES);
   localparam logic [7:0]  c_RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
   localparam logic [7:0]  c_INVULN_LAST  = 8'(INVULN_FRAMES - 1);
   localparam logic [7:0]  c_COOLDOWN     = 8'(FIRE_COOLDOWN);

   state_t      r_state, w_state;
   logic        r_v, r_vv;
   logic [7:0]  r_cnt, w_cnt;
   logic [7:0]  r_cool, w_cool;
   logic [10:0] r_xpos, w_xpos;
   logic [1:0]  r_lives, w_lives;
   logic        r_dead, w_dead;
   logic        r_go, w_go;
   logic        r_fire, w_fire;

   logic        w_tick;
   logic        w_act;
   logic [11:0] w_xwide;
   logic [11:0] w_x_left;
   logic [11:0] w_x_right;

   assign w_tick = r_v & ~r_vv;
   // A hit in ALIVE pre-empts movement and firing on a coincident tick.
   assign w_act  = w_tick & (((r_state == ST_ALIVE) & ~bus.hit) | (r_state == ST_INVULN));

   // 12-bit arithmetic so the left step cannot wrap below zero.
   assign w_xwide   = {1'b0, r_xpos};
   assign w_x_left  = (w_xwide >= c_X_MIN + c_STEP) ? (w_xwide - c_STEP) : c_X_MIN;
   assign w_x_right = (w_xwide + c_STEP > c_X_MAX) ? c_X_MAX : (w_xwide + c_STEP);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_v     <= 1'b0;
         r_vv    <= 1'b0;
         r_state <= ST_ALIVE;
         r_cnt   <= 8'd0;
         r_cool  <= 8'd0;
         r_xpos  <= c_X_START;
         r_lives <= c_LIVES;
         r_dead  <= 1'b0;
         r_go    <= 1'b0;
         r_fire  <= 1'b0;
      end else begin
         r_v     <= bus.vblnk_in;
         r_vv    <= r_v;
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_cool  <= w_cool;
         r_xpos  <= w_xpos;
         r_lives <= w_lives;
         r_dead  <= w_dead;
         r_go    <= w_go;
         r_fire  <= w_fire;
      end
   end

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_cool  = r_cool;
      w_xpos  = r_xpos;
      w_lives = r_lives;
      w_fire  = 1'b0;
      w_dead  = 1'b0;
      w_go    = 1'b0;

      if (w_tick && (r_cool != 8'd0)) begin
         w_cool = r_cool - 8'd1;
      end

      if (w_act) begin
         if (bus.left_btn && !bus.right_btn) begin
            w_xpos = w_x_left[10:0];
         end else if (bus.right_btn && !bus.left_btn) begin
            w_xpos = w_x_right[10:0];
         end
         if (bus.fire_btn && (r_cool == 8'd0)) begin
            w_fire = 1'b1;
            w_cool = c_COOLDOWN;
         end
      end

      case (r_state)
         ST_ALIVE: begin
            if (bus.hit) begin
               w_lives = r_lives - 2'd1;
               w_cnt   = 8'd0;
               w_state = (r_lives <= 2'd1) ? ST_GAME_OVER : ST_DEAD;
            end
         end
         ST_DEAD: begin
            if (w_tick) begin
               if (r_cnt == c_RESPAWN_LAST) begin
                  w_state = ST_INVULN;
                  w_cnt   = 8'd0;
                  w_xpos  = c_X_START;
               end else begin
                  w_cnt = r_cnt + 8'd1;
               end
            end
         end
         ST_INVULN: begin
            if (w_tick) begin
               if (r_cnt == c_INVULN_LAST) begin
                  w_state = ST_ALIVE;
                  w_cnt   = 8'd0;
               end else begin
                  w_cnt = r_cnt + 8'd1;
               end
            end
         end
         ST_GAME_OVER: begin
            if (bus.restart) begin
               w_state = ST_ALIVE;
               w_lives = c_LIVES;
               w_xpos  = c_X_START;
               w_cool  = 8'd0;
               w_cnt   = 8'd0;
            end
         end
         default: w_state = ST_ALIVE;
      endcase

      case (w_state)
         ST_DEAD, ST_GAME_OVER: w_dead = 1'b1;
`ifdef SHIP_BLINK_EN
         ST_INVULN:             w_dead = w_cnt[3];
`else
         ST_INVULN:             w_dead = 1'b0;
`endif
         default:               w_dead = 1'b0;
      endcase
      w_go = (w_state == ST_GAME_OVER);
   end

   assign bus.xpos       = r_xpos;
   assign bus.dead_ship  = r_dead;
   assign bus.lives      = r_lives;
   assign bus.game_over  = r_go;
   assign bus.fire_pulse = r_fire;

endmodule

`default_nettype wire
